sync_fifo_flagged: RTL and testbench
====================================

Name:
sync_fifo_flagged

Overview:
Single-clock, parametrised successor to the team's CDC FIFO, for blocks whose producer and consumer share one clock. It keeps the same increment-style handshake. It adds:
- configurable depth and width
- first-word-fall-through read data
- an occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow/underflow error flags with software clear

Parameters:
- DATA_WIDTH, 4, bits per entry
- ADDRESS_WIDTH, 5, log2 of depth; DEPTH = 2**ADDRESS_WIDTH entries
- ALMOST_FULL_LEVEL, 28, almost_full asserted when level >= this (1..DEPTH)
- ALMOST_EMPTY_LEVEL, 4, almost_empty asserted when level <= this (0..DEPTH-1)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- write_data  in  DATA_WIDTH  entry to push
- write_increment  in  1  push request, sampled on the rising clock edge
- read_increment  in  1  pop request, sampled on the rising clock edge
- clear_errors  in  1  clears the sticky overflow/underflow flags
- read_data  out  DATA_WIDTH  head entry (first-word fall-through)
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL
- almost_full  out  1  level >= ALMOST_FULL_LEVEL
- level  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was attempted while full
- underflow  out  1  sticky: a pop was attempted while empty

Behaviour:
- State registers:
  - write_pointer and read_pointer, ADDRESS_WIDTH bits each, wrapping modulo DEPTH
  - level, ADDRESS_WIDTH+1 bits
  - overflow and underflow
  - storage array of DEPTH x DATA_WIDTH; storage is not reset
- Reset, asynchronous: pointers = 0, level = 0, overflow = underflow = 0. Outputs during and immediately after reset:
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - read_data = 0
- Status flags are combinational decodes of level only. They change in the same cycle level updates, with no extra latency.
- Push accepted iff write_increment && !full, using pre-edge flags. On acceptance:
  - storage[write_pointer] <= write_data
  - write_pointer increments and wraps from DEPTH-1 to 0
- Pop accepted iff read_increment && !empty, using pre-edge flags. On acceptance, read_pointer increments and wraps the same way.
- Level update per edge:
  - push only: +1
  - pop only: -1
  - both accepted: unchanged, and the pointers still both advance
  - neither: unchanged
- Simultaneous push and pop at the boundaries:
  - When full, the push is rejected even if a pop is requested in the same cycle. The pop is accepted, so the level becomes DEPTH-1.
  - When empty, the pop is rejected even if a push is requested. The push is accepted, so the level becomes 1.
- Read data:
  - read_data = storage[read_pointer] whenever !empty, and 0 when empty.
  - New head data appears in the cycle after the write that makes the FIFO non-empty. Write-to-read latency is 1 clock.
  - After an accepted pop, the next entry is visible in the following cycle.
- Rejected requests leave pointers, level and storage untouched.
- overflow is set on any edge with write_increment && full. underflow is set on any edge with read_increment && empty.
- Error flags stay set until an edge with clear_errors = 1. If set and clear occur in the same edge, set wins.
- clear_errors has no effect on data, pointers or level.
- Inputs are synchronous to clock; no internal synchronisers.

Test Plan:
1. Reset, then idle 3 cycles -> empty=1, almost_empty=1, full=0, almost_full=0, level=0, read_data=0, overflow=underflow=0.
2. Push 0x1..0xF then 0x0, repeated twice (32 pushes, the defaults) -> level counts 1..32. almost_empty deasserts at level 5; almost_full asserts at level 28; full asserts at level 32. read_data=0x1 from the cycle after the first push.
3. From full, push 0xA for one cycle -> overflow=1, level stays 32. Pop all 32 -> data order 0x1..0xF,0x0 twice, ending empty. Pop once more -> underflow=1, level=0.
4. Hold push and pop together for 40 cycles at level 10 -> level stays 10, data out equals data in delayed by 10 entries, and both pointers wrap past 31 cleanly.
5. At full, assert push and pop together -> level=31, overflow=1, the head advances by one. At empty, assert both -> level=1, underflow=1, read_data equals the pushed value next cycle.
6. With overflow=1, assert clear_errors and push-while-full in the same cycle -> overflow stays 1. Clear alone next cycle -> overflow=0. Assert reset mid-fill at level 17 -> level=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// -----------------------------------------------------------------------------
// sync_fifo_flagged
//
// Single-clock FIFO for producer/consumer pairs that share one clock. It keeps
// the increment-style handshake of the team's CDC FIFO and adds:
//   - parametrised depth and width
//   - first-word-fall-through read data
//   - an occupancy count
//   - programmable almost-full / almost-empty thresholds
//   - sticky overflow / underflow error flags with a software clear
//
// Parameters:
//   DATA_WIDTH          bits per entry
//   ADDRESS_WIDTH       log2 of depth; DEPTH = 2**ADDRESS_WIDTH entries
//   ALMOST_FULL_LEVEL   almost_full  when level >= this (1..DEPTH)
//   ALMOST_EMPTY_LEVEL  almost_empty when level <= this (0..DEPTH-1)
//
// Ports:
//   clock            in   sole clock, rising edge
//   reset            in   asynchronous, active-high; clears all state except storage
//   write_data       in   entry to push
//   write_increment  in   push request, sampled on the rising edge
//   read_increment   in   pop request, sampled on the rising edge
//   clear_errors     in   clears the sticky overflow/underflow flags
//   read_data        out  head entry (first-word fall-through), 0 when empty
//   empty            out  level == 0
//   full             out  level == DEPTH
//   almost_empty     out  level <= ALMOST_EMPTY_LEVEL
//   almost_full      out  level >= ALMOST_FULL_LEVEL
//   level            out  current occupancy, 0..DEPTH
//   overflow         out  sticky: a push was attempted while full
//   underflow        out  sticky: a pop was attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flagged #(
  parameter int DATA_WIDTH         = 4,
  parameter int ADDRESS_WIDTH      = 5,
  parameter int ALMOST_FULL_LEVEL  = 28,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_increment,
  input  logic                     read_increment,
  input  logic                     clear_errors,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  // Thresholds and constants sized to the level / pointer widths so every
  // comparison and increment below is width-exact.
  localparam logic [ADDRESS_WIDTH:0]   LEVEL_DEPTH = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   LEVEL_AF    = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0]   LEVEL_AE    = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDRESS_WIDTH:0]   LEVEL_ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE     = {{(ADDRESS_WIDTH - 1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]    storage [DEPTH];
  logic [ADDRESS_WIDTH-1:0] write_pointer;
  logic [ADDRESS_WIDTH-1:0] read_pointer;

  logic push_accept;
  logic pop_accept;

  // ---------------------------------------------------------------------------
  // Status decode: purely combinational from level, so flags move in the same
  // cycle as the occupancy with no extra register stage.
  // ---------------------------------------------------------------------------
  assign empty        = (level == '0);
  assign full         = (level == LEVEL_DEPTH);
  assign almost_empty = (level <= LEVEL_AE);
  assign almost_full  = (level >= LEVEL_AF);

  // Acceptance uses the pre-edge flags. At full a simultaneous pop does not
  // make room for the push in the same edge, and at empty a simultaneous push
  // does not feed the pop: each side only looks at its own boundary.
  assign push_accept = write_increment && !full;
  assign pop_accept  = read_increment  && !empty;

  // First-word fall-through: the head slot is presented directly. The value
  // is masked while empty so stale storage never leaks out after reset or
  // after the last pop.
  assign read_data = empty ? '0 : storage[read_pointer];

  // ---------------------------------------------------------------------------
  // Data array
  // ---------------------------------------------------------------------------
  // NOTE: storage has no reset branch. Entries are only observable once the
  // level says they were written, so clearing them would buy nothing and
  // would keep the array from mapping onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_accept) begin
      storage[write_pointer] <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: every register here is updated with non-blocking assignments so
  // all of them see the same pre-edge values of level, full and empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      level         <= '0;
    end else begin
      // Pointers are exactly ADDRESS_WIDTH bits, so DEPTH-1 + 1 wraps to 0.
      if (push_accept) begin
        write_pointer <= write_pointer + PTR_ONE;
      end
      if (pop_accept) begin
        read_pointer <= read_pointer + PTR_ONE;
      end

      // Simultaneous accepted push and pop leave the level unchanged while
      // both pointers still advance.
      unique case ({push_accept, pop_accept})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  // A request at the boundary sets the flag whether or not the other side
  // of the handshake was accepted. The set term is OR-ed after the clear so
  // a fresh error in the clearing edge is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_errors) || (write_increment && full);
      underflow <= (underflow && !clear_errors) || (read_increment  && empty);
    end
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flagged
//
// Self-checking bench for sync_fifo_flagged with default parameters. A driver
// process walks through directed phases followed by a random phase. A separate
// monitor process keeps a queue-based reference model: on each falling edge it
// compares every DUT output against the model, pops the expected head when a
// pop will be accepted, and pushes new data when a push will be accepted.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flagged;

  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] write_data = '0;
  logic          write_increment = 1'b0;
  logic          read_increment = 1'b0;
  logic          clear_errors = 1'b0;
  logic [DW-1:0] read_data;
  logic          empty, full, almost_empty, almost_full;
  logic [AW:0]   level;
  logic          overflow, underflow;

  int tests = 0;
  int fails = 0;

  sync_fifo_flagged #(
    .DATA_WIDTH        (DW),
    .ADDRESS_WIDTH     (AW),
    .ALMOST_FULL_LEVEL (AF),
    .ALMOST_EMPTY_LEVEL(AE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .write_data     (write_data),
    .write_increment(write_increment),
    .read_increment (read_increment),
    .clear_errors   (clear_errors),
    .read_data      (read_data),
    .empty          (empty),
    .full           (full),
    .almost_empty   (almost_empty),
    .almost_full    (almost_full),
    .level          (level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and monitor
  // ---------------------------------------------------------------------------
  logic [DW-1:0] model_q[$];
  bit            model_ovf = 1'b0;
  bit            model_unf = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
      end
      begin
        int  n;
        bit  was_full;
        bit  was_empty;
        logic [DW-1:0] head;
        n         = model_q.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        head      = was_empty ? '0 : model_q[0];

        check("level",        32'(level),        32'(n));
        check("empty",        32'(empty),        32'(was_empty));
        check("full",         32'(full),         32'(was_full));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("almost_full",  32'(almost_full),  32'(n >= AF));
        check("read_data",    32'(read_data),    32'(head));
        check("overflow",     32'(overflow),     32'(model_ovf));
        check("underflow",    32'(underflow),    32'(model_unf));

        if (!reset) begin
          // The consumer takes the head this edge: it must be the oldest
          // entry the producer handed over.
          if (read_increment && !was_empty) begin
            check("pop_data", 32'(read_data), 32'(model_q.pop_front()));
          end
          if (write_increment && !was_full) begin
            model_q.push_back(write_data);
          end
          model_ovf = (model_ovf && !clear_errors) || (write_increment && was_full);
          model_unf = (model_unf && !clear_errors) || (read_increment && was_empty);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic wr, input logic rd, input logic clr,
                       input logic [DW-1:0] d);
    write_increment = wr;
    read_increment  = rd;
    clear_errors    = clr;
    write_data      = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset and idle.
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(3);
    check("idle_level", 32'(level), 32'd0);
    check("idle_read_data", 32'(read_data), 32'd0);

    // Fill with 0x1..0xF,0x0 twice.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, DW'(i + 1));
    end
    check("fill_full", 32'(full), 32'd1);

    // Push while full, then drain everything, then pop while empty.
    cycle(1'b1, 1'b0, 1'b0, 4'hA);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    idle(1);
    check("drain_underflow", 32'(underflow), 32'd1);

    // Steady streaming at level 10 across pointer wrap.
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, DW'($urandom));
    check("stream_level", 32'(level), 32'd10);

    // Push+pop at full, then push+pop at empty.
    for (int i = 0; i < DEPTH - 10; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b1, 1'b0, DW'($urandom));
    check("full_both_level", 32'(level), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 4'h7);
    check("empty_both_level", 32'(level), 32'd1);
    check("empty_both_data", 32'(read_data), 32'h7);

    // Clear colliding with a new overflow, then a clean clear.
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b0, 1'b0, 4'h3);
    cycle(1'b1, 1'b0, 1'b1, 4'h3);
    check("set_beats_clear", 32'(overflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("clear_alone", 32'(overflow), 32'd0);

    // Asynchronous reset mid-fill at level 17.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    check("pre_reset_level", 32'(level), 32'd17);
    #2;
    reset = 1'b1;
    #1;
    check("async_level", 32'(level), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_read_data", 32'(read_data), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random traffic with occasional error clears.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 5), DW'($urandom));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
